ftdi_echo_engine: RTL and testbench

FTDI_ECHO_ENGINE -- requirements
Module: ftdi_echo_engine

---
 rtl/ftdi_echo_pkg.sv | 25 ++
 rtl/echo_fifo.sv | 60 ++++++
 rtl/ftdi_echo_engine.sv | 185 ++++++++++++++++++
 tb/tb_ftdi_echo_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_echo_pkg.sv
// Shared types for the FTDI echo engine: echo modes, FSM states and bus width.
package ftdi_echo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOOPBACK = 2'b00,
    COUNT    = 2'b01,
    INVERT   = 2'b10,
    DISCARD  = 2'b11
  } echo_mode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_WAIT,
    ST_RD_LOW,
    ST_RD_HIGH,
    ST_TURN,
    ST_TX_WAIT,
    ST_WR_LOW,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/echo_fifo.sv
// Show-ahead byte FIFO holding one packet; also exposes the entry behind the head
// so the consumer can preload its output register on the same edge it pops.
module echo_fifo
  import ftdi_echo_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] head,
  output logic [BYTE_W-1:0] next_head,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem [0:(2**AW)-1];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     count;

  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign head       = mem[rd_ptr];
  assign next_head  = mem[rd_ptr_nxt];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ftdi_echo_engine.sv
// FTDI FIFO-bus echo engine: reads a packet of PKT_LEN bytes, then writes it back
// (looped, inverted, counted) or drops it, with fully registered bus strobes.
module ftdi_echo_engine
  import ftdi_echo_pkg::*;
#(
  parameter int PKT_LEN    = 64,
  parameter int FIFO_DEPTH = 64,
  localparam int CT_W      = $clog2(PKT_LEN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic              rxf,
  input  logic              txe,
  input  logic [BYTE_W-1:0] adbus_in,
  output logic              ftdi_rd,
  output logic              ftdi_wr,
  output logic              adbus_tri,
  output logic [BYTE_W-1:0] adbus_out,
  output logic [CT_W-1:0]   rd_ct,
  output logic [CT_W-1:0]   wr_ct,
  output logic [15:0]       pkt_count,
  output logic              pkt_done,
  output logic              busy
);

  if (PKT_LEN < 1 || PKT_LEN > 256 || FIFO_DEPTH < PKT_LEN ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "ftdi_echo_engine: illegal PKT_LEN/FIFO_DEPTH combination");
  end

  state_t            state;
  echo_mode_t        mode_q;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic              fifo_full;
  logic [BYTE_W-1:0] fifo_head;
  logic [BYTE_W-1:0] fifo_next;
  logic [CT_W-1:0]   wr_ct_inc;
  logic              rd_last;

  function automatic logic [BYTE_W-1:0] echo_byte(input echo_mode_t m,
                                                  input logic [BYTE_W-1:0] data,
                                                  input logic [CT_W-1:0] idx);
    logic [CT_W+BYTE_W-1:0] idx_ext;
    idx_ext = {{BYTE_W{1'b0}}, idx};
    case (m)
      INVERT:  echo_byte = ~data;
      COUNT:   echo_byte = idx_ext[BYTE_W-1:0];
      default: echo_byte = data;
    endcase
  endfunction

  assign wr_ct_inc  = wr_ct + CT_W'(1);
  assign rd_last    = (rd_ct == CT_W'(PKT_LEN));
  assign fifo_push  = (state == ST_RD_LOW) && !clear;
  assign fifo_pop   = (state == ST_WR_HOLD) && !clear;
  assign fifo_flush = clear || (state == ST_DONE);

  echo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .din       (adbus_in),
    .head      (fifo_head),
    .next_head (fifo_next),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs are assigned alongside each transition so they describe the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= LOOPBACK;
      ftdi_rd   <= 1'b1;
      ftdi_wr   <= 1'b1;
      adbus_tri <= 1'b0;
      adbus_out <= '0;
      rd_ct     <= '0;
      wr_ct     <= '0;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      ftdi_rd   <= 1'b1;
      ftdi_wr   <= 1'b1;
      adbus_tri <= 1'b0;
      adbus_out <= '0;
      rd_ct     <= '0;
      wr_ct     <= '0;
      pkt_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ftdi_rd  <= 1'b1;
      ftdi_wr  <= 1'b1;
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state  <= ST_RX_WAIT;
            mode_q <= echo_mode_t'(mode);
            busy   <= 1'b1;
          end
        end
        ST_RX_WAIT: begin
          if (!rxf && en) begin
            state   <= ST_RD_LOW;
            ftdi_rd <= 1'b0;
          end
        end
        ST_RD_LOW: begin
          state <= ST_RD_HIGH;
          rd_ct <= rd_ct + CT_W'(1);
        end
        ST_RD_HIGH: begin
          if (rd_last && mode_q == DISCARD) begin
            state     <= ST_DONE;
            pkt_done  <= 1'b1;
            rd_ct     <= '0;
            wr_ct     <= '0;
            pkt_count <= pkt_count + 16'd1;
          end else if (rd_last) begin
            state     <= ST_TURN;
            adbus_tri <= 1'b1;
          end else if (!rxf && en) begin
            state   <= ST_RD_LOW;
            ftdi_rd <= 1'b0;
          end else begin
            state <= ST_RX_WAIT;
          end
        end
        ST_TURN: begin
          state     <= ST_TX_WAIT;
          adbus_out <= echo_byte(mode_q, fifo_head, '0);
        end
        ST_TX_WAIT: begin
          if (!txe && en) begin
            state   <= ST_WR_LOW;
            ftdi_wr <= 1'b0;
          end
        end
        ST_WR_LOW: begin
          state <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          wr_ct <= wr_ct_inc;
          if (wr_ct_inc == CT_W'(PKT_LEN)) begin
            state     <= ST_DONE;
            pkt_done  <= 1'b1;
            adbus_tri <= 1'b0;
            rd_ct     <= '0;
            wr_ct     <= '0;
            pkt_count <= pkt_count + 16'd1;
          end else begin
            state     <= ST_TX_WAIT;
            adbus_out <= echo_byte(mode_q, fifo_next, wr_ct_inc);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          adbus_tri <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clock) disable iff (reset) !(fifo_push && fifo_full));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(fifo_pop && fifo_empty));
  a_strobe_excl:  assert property (@(posedge clock) disable iff (reset) !(!ftdi_rd && !ftdi_wr));
  a_no_rd_drive:  assert property (@(posedge clock) disable iff (reset) !(!ftdi_rd && adbus_tri));

endmodule

// File: tb/tb_ftdi_echo_engine.sv
// Bench for ftdi_echo_engine: FTDI bus model, directed vector table, hand-written
// stall/clear/reset sequences and randomized packets against a per-byte reference.
module tb_ftdi_echo_engine;

  localparam int PKT_LEN = 4;
  localparam int CT_W    = $clog2(PKT_LEN + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic            clear = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            rxf = 1'b1;
  logic            txe = 1'b0;
  logic [7:0]      adbus_in = 8'h00;
  logic            ftdi_rd;
  logic            ftdi_wr;
  logic            adbus_tri;
  logic [7:0]      adbus_out;
  logic [CT_W-1:0] rd_ct;
  logic [CT_W-1:0] wr_ct;
  logic [15:0]     pkt_count;
  logic            pkt_done;
  logic            busy;

  ftdi_echo_engine #(.PKT_LEN(PKT_LEN), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .mode(mode),
    .rxf(rxf), .txe(txe), .adbus_in(adbus_in),
    .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr), .adbus_tri(adbus_tri), .adbus_out(adbus_out),
    .rd_ct(rd_ct), .wr_ct(wr_ct), .pkt_count(pkt_count), .pkt_done(pkt_done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      mode;
    logic [3:0][7:0] rx;
    logic [3:0][7:0] exp;
    int              exp_n;
  } vec_t;

  vec_t       tbl [4];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         exp_pkts = 0;
  logic [7:0] rxq [$];
  logic [7:0] wrq [$];
  int         rd_log [$];
  int         wr_log [$];
  int         done_log [$];
  logic       rd_seen = 1'b0;
  logic       wr_seen = 1'b0;
  logic       tri_seen = 1'b0;
  logic       rand_stall = 1'b0;
  logic       rx_block = 1'b0;
  logic [7:0] prev_out = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [1:0] m, input logic [7:0] b, input int idx);
    case (m)
      2'b00:   return b;
      2'b01:   return idx[7:0];
      2'b10:   return ~b;
      default: return 8'h00;
    endcase
  endfunction

  // One clock of the FTDI side: sample at negedge, log strobes, advance the rx queue.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (!ftdi_rd) chk("rd_excl", {30'd0, ftdi_wr, adbus_tri}, 32'd2);
    if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
    rd_seen = !ftdi_rd;
    if (!ftdi_rd) rd_log.push_back(cyc);
    if (wr_seen) chk("wr_hold", {23'd0, ftdi_wr, adbus_out}, {23'd0, 1'b1, wrq[$]});
    wr_seen = !ftdi_wr;
    if (!ftdi_wr) begin
      chk("wr_setup", {24'd0, adbus_out}, {24'd0, prev_out});
      chk("wr_tri", {31'd0, adbus_tri}, 32'd1);
      wrq.push_back(adbus_out);
      wr_log.push_back(cyc);
    end
    prev_out = adbus_out;
    if (adbus_tri) tri_seen = 1'b1;
    if (pkt_done) done_log.push_back(cyc);
    if (rand_stall) begin
      rx_block = ($urandom_range(0, 2) == 0);
      txe      = ($urandom_range(0, 2) == 0);
      en       = ($urandom_range(0, 3) != 0);
    end
    rxf      = (rxq.size() == 0) || rx_block;
    adbus_in = (rxq.size() > 0) ? rxq[0] : 8'h00;
  endtask

  task automatic start_packet(input logic [1:0] m, input logic [3:0][7:0] rx, input int nbytes);
    wrq.delete(); rd_log.delete(); wr_log.delete(); done_log.delete();
    tri_seen = 1'b0;
    mode = m;
    for (int i = 0; i < nbytes; i++) rxq.push_back(rx[i]);
    en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_log.size() == 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done_log.size() > 0}, 32'd1);
    if (done_log.size() > 0) exp_pkts++;
    rand_stall = 1'b0; rx_block = 1'b0; txe = 1'b0; en = 1'b0;
    step();
    chk({tag, "_pkt_count"}, {16'd0, pkt_count}, exp_pkts);
    chk({tag, "_done_pulse"}, {31'd0, pkt_done}, 32'd0);
    chk({tag, "_idle"}, {28'd0, busy, adbus_tri, ftdi_rd, ftdi_wr}, 32'b0011);
    chk({tag, "_ct_clr"}, {26'd0, rd_ct, wr_ct}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [3:0][7:0] exp, input int n);
    chk({tag, "_nwr"}, wrq.size(), n);
    for (int i = 0; i < n; i++)
      if (i < wrq.size()) chk($sformatf("%s_b%0d", tag, i), {24'd0, wrq[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [3:0][7:0] rbytes;
    logic [3:0][7:0] rexp;
    logic [1:0]      rmode;
    logic            ok;
    int              n;

    tbl[0] = '{2'b00, 32'h44332211, 32'h44332211, 4};
    tbl[1] = '{2'b10, 32'hA55AFF00, 32'h5AA500FF, 4};
    tbl[2] = '{2'b01, 32'h9C9C9C9C, 32'h03020100, 4};
    tbl[3] = '{2'b11, 32'hDEADBEEF, 32'h00000000, 0};

    // Reset values
    step(); step();
    chk("rst_strobes", {29'd0, ftdi_rd, ftdi_wr, adbus_tri}, 32'b110);
    chk("rst_out", {24'd0, adbus_out}, 32'd0);
    chk("rst_cts", {26'd0, rd_ct, wr_ct}, 32'd0);
    chk("rst_pkts", {16'd0, pkt_count}, 32'd0);
    chk("rst_flags", {30'd0, pkt_done, busy}, 32'd0);
    reset = 1'b0;
    step();

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      start_packet(tbl[v].mode, tbl[v].rx, 4);
      wait_done($sformatf("tbl%0d", v), 200);
      check_out($sformatf("tbl%0d", v), tbl[v].exp, tbl[v].exp_n);
      chk($sformatf("tbl%0d_rd_rate", v), rd_log.size() == 4 ? rd_log[3] - rd_log[0] : -1, 6);
      if (tbl[v].exp_n > 0) begin
        chk($sformatf("tbl%0d_wr_rate", v), wr_log.size() == 4 ? wr_log[3] - wr_log[0] : -1, 9);
      end else begin
        chk("discard_tri", {31'd0, tri_seen}, 32'd0);
        chk("discard_done_t", (done_log.size() > 0 && rd_log.size() == 4) ?
            done_log[0] - rd_log[3] : -1, 2);
      end
    end

    // rxf and txe stalls in the middle of a loopback packet
    start_packet(2'b00, 32'h000000B2A1, 2);
    n = 0;
    while (rd_ct != 2 && n < 100) begin step(); n++; end
    chk("stall_rd2", {29'd0, rd_ct}, 32'd2);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!ftdi_rd || rd_ct != 2) ok = 1'b0;
    end
    chk("stall_rx_hold", {31'd0, ok}, 32'd1);
    rxq.push_back(8'hC3); rxq.push_back(8'hD4);
    n = 0;
    while (wr_ct != 1 && n < 100) begin step(); n++; end
    chk("stall_wr1", {29'd0, wr_ct}, 32'd1);
    txe = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!ftdi_wr || wr_ct != 1) ok = 1'b0;
    end
    chk("stall_tx_hold", {31'd0, ok}, 32'd1);
    txe = 1'b0;
    wait_done("stall", 200);
    check_out("stall", 32'hD4C3B2A1, 4);

    // Randomized packets with random rxf/txe/en stalls
    for (int p = 0; p < 8; p++) begin
      rmode  = 2'($urandom_range(0, 3));
      rbytes = $urandom;
      for (int i = 0; i < 4; i++) rexp[i] = ref_byte(rmode, rbytes[i], i);
      start_packet(rmode, rbytes, 4);
      rand_stall = 1'b1;
      wait_done($sformatf("rnd%0d", p), 600);
      check_out($sformatf("rnd%0d", p), rexp, (rmode == 2'b11) ? 0 : 4);
    end

    // Clear in WR_HOLD of byte 2
    start_packet(2'b00, 32'h55667788, 4);
    n = 0;
    while (!(wrq.size() == 2 && !ftdi_wr) && n < 200) begin step(); n++; end
    chk("clr_reach", wrq.size(), 2);
    step();
    clear = 1'b1; en = 1'b0;
    step();
    clear = 1'b0;
    chk("clr_strobes", {29'd0, ftdi_rd, ftdi_wr, adbus_tri}, 32'b110);
    chk("clr_cts", {26'd0, rd_ct, wr_ct}, 32'd0);
    chk("clr_flags", {30'd0, pkt_done, busy}, 32'd0);
    chk("clr_pkts", {16'd0, pkt_count}, exp_pkts);
    step();
    chk("clr_no_done", {31'd0, pkt_done}, 32'd0);
    start_packet(2'b00, 32'h08070605, 4);
    wait_done("post_clr", 200);
    check_out("post_clr", 32'h08070605, 4);

    // Asynchronous reset during RD_LOW
    start_packet(2'b10, 32'h99AABBCC, 4);
    n = 0;
    while (ftdi_rd && n < 100) begin step(); n++; end
    chk("rst_reach_rd", {31'd0, ftdi_rd}, 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_strobes", {29'd0, ftdi_rd, ftdi_wr, adbus_tri}, 32'b110);
    chk("arst_cts", {26'd0, rd_ct, wr_ct}, 32'd0);
    chk("arst_pkts", {16'd0, pkt_count}, 32'd0);
    chk("arst_flags", {30'd0, pkt_done, busy}, 32'd0);
    exp_pkts = 0;
    rxq.delete(); rd_seen = 1'b0; wr_seen = 1'b0; en = 1'b0;
    step();
    reset = 1'b0;
    step();
    start_packet(2'b00, 32'h04030201, 4);
    wait_done("post_rst", 200);
    check_out("post_rst", 32'h04030201, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
